lcd_addr_sequencer: RTL

Parametrised address sequencer for HD44780-class character LCDs. It holds the power-on init phase for a programmable number of cycles, then walks the DDRAM cursor address across any supported ROWS x COLS geometry with correct line base addresses, and walks the character-memory address across PAGES screens. It sits between the init/config command FSMs and the character memory, and adds restart, hold and end-of-line/frame/memory event strobes.

---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_init_timer.sv | 24 ++
 rtl/lcd_addr_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and DDRAM line-base helper for the LCD address sequencer.
package lcd_pkg;

    localparam int DDRAM_AW     = 7;
    localparam int LINE2_OFFSET = 64;

    typedef enum logic {
        INIT_WAIT = 1'b0,
        RUN       = 1'b1
    } lcd_state_t;

    // Odd rows sit at 0x40; rows 2/3 continue the first two lines after COLS cells.
    function automatic logic [DDRAM_AW-1:0] line_base(input logic [1:0] row, input int cols);
        int base;
        base = int'(row[0]) * LINE2_OFFSET + int'(row[1]) * cols;
        return DDRAM_AW'(base);
    endfunction

endpackage

// File: rtl/lcd_init_timer.sv
// Power-on delay counter: done rises once INIT_CYCLES-1 is reached and stays until reset.
module lcd_init_timer #(
    parameter int INIT_CYCLES = 964049
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    localparam int            CW   = $clog2(INIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(INIT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (count != LAST)
            count <= count + CW'(1);
    end

    assign done = (count == LAST);

endmodule

// File: rtl/lcd_addr_sequencer.sv
// DDRAM cursor and character-memory address sequencer with init hold-off,
// restart/hold control and registered end-of-line/frame/memory strobes.
module lcd_addr_sequencer
    import lcd_pkg::*;
#(
    parameter int INIT_CYCLES = 964049,
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int PAGES       = 2,
    parameter int MEM_AW      = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                change_addr,
    input  logic                change_memory_addr,
    input  logic                restart,
    input  logic                hold,
    output logic                start,
    output logic [6:0]          addr,
    output logic [MEM_AW-1:0]   memory_addr,
    output logic [1:0]          row,
    output logic [5:0]          col,
    output logic                line_end,
    output logic                frame_end,
    output logic                mem_wrap
);

    generate
        if (COLS < 1 || COLS > 40 || ROWS < 1 || ROWS > 4 || (ROWS > 2 && COLS > 20) ||
            PAGES < 1 || PAGES * ROWS * COLS > 2 ** MEM_AW) begin : g_bad_geometry
            $error("lcd_addr_sequencer: illegal COLS/ROWS/PAGES/MEM_AW combination");
        end
    endgenerate

    localparam logic [5:0]        COL_LAST = 6'(COLS - 1);
    localparam logic [1:0]        ROW_LAST = 2'(ROWS - 1);
    localparam logic [MEM_AW-1:0] MEM_LAST = MEM_AW'(PAGES * ROWS * COLS - 1);

    lcd_state_t state, state_next;
    logic       init_done;

    logic [1:0]        row_next;
    logic [5:0]        col_next;
    logic [MEM_AW-1:0] mem_next;
    logic              line_end_next, frame_end_next, mem_wrap_next;

    lcd_init_timer #(.INIT_CYCLES(INIT_CYCLES)) u_init_timer (
        .clk   (clk),
        .reset (reset),
        .done  (init_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= INIT_WAIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == INIT_WAIT && init_done)
            state_next = RUN;
    end

    always_comb begin
        start = (state == INIT_WAIT);
    end

    // Priority within RUN: restart, then hold, then the two independent advances.
    always_comb begin
        row_next       = row;
        col_next       = col;
        mem_next       = memory_addr;
        line_end_next  = 1'b0;
        frame_end_next = 1'b0;
        mem_wrap_next  = 1'b0;
        if (state == RUN) begin
            if (restart) begin
                row_next = '0;
                col_next = '0;
                mem_next = '0;
            end else if (!hold) begin
                if (change_addr) begin
                    if (col == COL_LAST) begin
                        col_next      = '0;
                        line_end_next = 1'b1;
                        if (row == ROW_LAST) begin
                            row_next       = '0;
                            frame_end_next = 1'b1;
                        end else begin
                            row_next = row + 2'd1;
                        end
                    end else begin
                        col_next = col + 6'd1;
                    end
                end
                if (change_memory_addr) begin
                    if (memory_addr == MEM_LAST) begin
                        mem_next      = '0;
                        mem_wrap_next = 1'b1;
                    end else begin
                        mem_next = memory_addr + MEM_AW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row         <= '0;
            col         <= '0;
            addr        <= '0;
            memory_addr <= '0;
            line_end    <= 1'b0;
            frame_end   <= 1'b0;
            mem_wrap    <= 1'b0;
        end else begin
            row         <= row_next;
            col         <= col_next;
            addr        <= line_base(row_next, COLS) + DDRAM_AW'(col_next);
            memory_addr <= mem_next;
            line_end    <= line_end_next;
            frame_end   <= frame_end_next;
            mem_wrap    <= mem_wrap_next;
        end
    end

endmodule
